alux_exec: RTL and testbench
============================

Name: alux_exec

Overview:
- Sequential execute unit directly downstream of the 16x64 register bank.
- Consumes the bank's registered outA/outB as operands and computes one operation per start.
- Returns the result through a write-back port: wbdata to the bank's inA, wbreg to selwreg, wben to regwen.
- Shifts and multiply are iterative (one bit per cycle); logic and add/sub complete in one cycle.

Parameters:
- DW, 64, operand/result width; must be even.
- RW, 4, register index width (16 registers).
- SHW, 6, shift-amount width (log2 DW).

Ports:
- clock  in  1  master clock, posedge
- reset  in  1  asynchronous reset, active high
- start  in  1  launch operation; sampled only when busy=0
- opcode  in  4  operation select, see Behaviour
- opA  in  DW  operand A (bank outA)
- opB  in  DW  operand B (bank outB); opB[SHW-1:0] is the shift amount
- dstreg  in  RW  destination register index for write-back
- busy  out  1  high while an iterative op runs
- done  out  1  one-cycle pulse, result valid
- wbdata  out  DW  result, registered, held until next done
- wbreg  out  RW  latched dstreg, held with wbdata
- wben  out  1  one-cycle write-back strobe, coincident with done for legal ops
- flagz  out  1  wbdata==0, updated at done
- flagc  out  1  carry (ADD) / borrow (SUB), 0 for other ops, updated at done
- err  out  1  one-cycle pulse with done for an illegal opcode

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; busy, done, wben, err, flagz, flagc=0; wbdata=0; wbreg=0; internal counters/accumulators cleared. No write-back is ever issued for an aborted op.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 PASSA, 6 SHL, 7 SHR (logical), 8 SAR (arithmetic), 9 MUL (unsigned opA[DW/2-1:0]*opB[DW/2-1:0], full DW result), 10-15 illegal.
- FSM states:
  - IDLE: start sampled at edge k with busy=0; opA, opB, opcode, dstreg latched at edge k.
  - Opcodes 0-5, illegal, and shifts with amount 0: done at edge k+1; state stays IDLE.
  - Shifts with amount N>0: IDLE->SHIFT; one bit per cycle; done at edge k+N (max k+DW-1).
  - MUL: IDLE->MUL; shift-add, DW/2 iterations; done at edge k+DW/2 (k+32 at default).
  - SHIFT/MUL exit: on the final iteration, return to IDLE and pulse done/wben.
- busy=1 exactly while in SHIFT or MUL.
- start while busy=1 is ignored; it is not queued.
- Back-to-back: start may be asserted in the cycle done=1, since state is already IDLE; the new op is accepted.
- ADD/SUB: DW-bit wrap-around. flagc = bit DW of A+B, or the borrow of A-B (1 when A<B unsigned).
- Illegal opcode: done=1, err=1, wben=0; wbdata, wbreg, and flags are unchanged.
- Operand inputs may change freely after the start edge; only the latched copies are used.

Optional Feature:
- Macro: ALUX_EXEC_MUL_EN.
- Defined: opcode 9 performs the iterative multiply and the MUL state exists.
- Undefined: the MUL state and multiplier datapath are not compiled; opcode 9 is illegal (done+err at k+1, no write-back).

Decomposition:
- Shared package alux_pkg:
  - opcode constants (OP_ADD .. OP_MUL)
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_MUL)
  - DW/RW/SHW defaults, shared with the register bank.
- One natural sub-module, alux_exec_mul: the shift-add multiplier core with load/step/last interface, instantiated only under ALUX_EXEC_MUL_EN.
- Shifter and single-cycle ops stay in the top.

Test Plan:
- ADD, opA=64'hFFFF_FFFF_FFFF_FFFF, opB=1, dstreg=3 -> at k+1: done=wben=1, wbdata=0, wbreg=3, flagz=1, flagc=1.
- SUB, opA=5, opB=7 -> at k+1: wbdata=64'hFFFF_FFFF_FFFF_FFFE, flagc=1, flagz=0.
- SAR, opA=64'h8000_0000_0000_0000, opB=4 -> busy for cycles k+1..k+3, done at k+4, wbdata=64'hF800_0000_0000_0000; start pulses during busy are ignored.
- MUL (macro defined), opA=32'hFFFF_FFFF, opB=32'hFFFF_FFFF -> done at k+32, wbdata=64'hFFFF_FFFE_0000_0001. Without the macro -> err=1, wben=0 at k+1.
- Reset asserted at cycle k+10 of a MUL -> busy, done, wben drop immediately; no write-back follows; the next ADD 2+3 yields wbdata=5 at k+1.
- Back-to-back: start held high across an XOR then an AND -> two done pulses on consecutive cycles with correct wbdata each.

Source files
------------

// File: rtl/alux_pkg.sv
// alux_pkg: shared definitions for the execute unit and the 16x64 register bank.
//   - ALUX_DW / ALUX_RW / ALUX_SHW : default data, register-index and shift-amount widths
//   - OP_* : opcode encodings
//   - state_t : execute-unit FSM states
//   - is_shift() : true for the three iterative shift opcodes
package alux_pkg;

  localparam int ALUX_DW  = 64;
  localparam int ALUX_RW  = 4;
  localparam int ALUX_SHW = 6;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_PASSA = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SAR   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/alux_exec_mul.sv
// alux_exec_mul: iterative shift-add multiplier, one multiplier bit per step.
//   clock, reset : clock and asynchronous active-high reset
//   load         : capture a/b and clear the product
//   step         : perform one add-and-shift iteration
//   a, b         : DW/2-bit unsigned operands
//   last         : the current step is the final (DW/2-th) iteration
//   result       : product including the current step's partial term; full
//                  product when sampled together with step && last
module alux_exec_mul #(
  parameter int DW = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic [DW/2-1:0] a,
  input  logic [DW/2-1:0] b,
  output logic            last,
  output logic [DW-1:0]   result
);

  localparam int HW = DW / 2;
  localparam int CW = (HW > 1) ? $clog2(HW) : 1;

  logic [DW-1:0] mcand;
  logic [HW-1:0] mplier;
  logic [DW-1:0] prod;
  logic [CW-1:0] cnt;

  // Exposing the sum of this step lets the caller capture the finished product
  // on the same edge as the final iteration, with no extra drain cycle.
  assign result = prod + (mplier[0] ? mcand : '0);
  assign last   = (cnt == CW'(HW - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {{(DW - HW){1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      prod   <= result;
      mcand  <= {mcand[DW-2:0], 1'b0};
      mplier <= {1'b0, mplier[HW-1:1]};
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alux_exec.sv
// alux_exec: sequential execute unit behind the register bank.
//   clock, reset   : master clock, asynchronous active-high reset
//   start, opcode  : launch request (taken only while idle) and operation
//   opA, opB       : operands from the bank; opB[SHW-1:0] is the shift amount
//   dstreg         : write-back register index
//   busy           : iterative shift or multiply in progress
//   done           : one-cycle completion pulse
//   wbdata, wbreg  : registered result and destination, held until next done
//   wben           : write-back strobe (legal ops only)
//   flagz, flagc   : zero flag, carry/borrow flag, updated on legal completion
//   err            : illegal-opcode pulse, coincident with done
// Build option: define ALUX_EXEC_MUL_EN to include the iterative multiplier
// (opcode 9); without it opcode 9 is treated as illegal.
module alux_exec
  import alux_pkg::*;
#(
  parameter int DW  = ALUX_DW,
  parameter int RW  = ALUX_RW,
  parameter int SHW = ALUX_SHW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] opA,
  input  logic [DW-1:0] opB,
  input  logic [RW-1:0] dstreg,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] wbdata,
  output logic [RW-1:0] wbreg,
  output logic          wben,
  output logic          flagz,
  output logic          flagc,
  output logic          err
);

  state_t         state, state_next;
  logic [DW-1:0]  a_lat, b_lat;
  logic [3:0]     op_lat;
  logic [RW-1:0]  dst_lat;
  logic           pend;        // single-cycle op latched last edge, completes this edge
  logic [DW-1:0]  shreg;
  logic [SHW-1:0] cnt;

  logic           accept, launch_single, go_shift, shift_last;
  logic [SHW-1:0] sh_in;
  logic [DW-1:0]  sh_step;
  logic [DW-1:0]  sc_res;
  logic           sc_c, sc_legal;

`ifdef ALUX_EXEC_MUL_EN
  logic           go_mul, mul_step, mul_last;
  logic [DW-1:0]  mul_res;

  alux_exec_mul #(.DW(DW)) u_mul (
    .clock  (clock),
    .reset  (reset),
    .load   (go_mul),
    .step   (mul_step),
    .a      (opA[DW/2-1:0]),
    .b      (opB[DW/2-1:0]),
    .last   (mul_last),
    .result (mul_res)
  );
`endif

  assign sh_in = opB[SHW-1:0];
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    launch_single = 1'b0;
    go_shift      = 1'b0;
    shift_last    = 1'b0;
`ifdef ALUX_EXEC_MUL_EN
    go_mul        = 1'b0;
    mul_step      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (is_shift(opcode) && (sh_in != '0)) begin
            go_shift   = 1'b1;
            state_next = ST_SHIFT;
          end
`ifdef ALUX_EXEC_MUL_EN
          else if (opcode == OP_MUL) begin
            go_mul     = 1'b1;
            state_next = ST_MUL;
          end
`endif
          else begin
            launch_single = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (cnt == SHW'(1)) begin
          shift_last = 1'b1;
          state_next = ST_IDLE;
        end
      end
`ifdef ALUX_EXEC_MUL_EN
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // One-bit shift of the working register, direction from the latched opcode.
  always_comb begin
    case (op_lat)
      OP_SHL:  sh_step = {shreg[DW-2:0], 1'b0};
      OP_SHR:  sh_step = {1'b0, shreg[DW-1:1]};
      default: sh_step = {shreg[DW-1], shreg[DW-1:1]};
    endcase
  end

  // Single-cycle result from the latched operands.
  always_comb begin
    sc_res   = a_lat;
    sc_c     = 1'b0;
    sc_legal = 1'b1;
    case (op_lat)
      OP_ADD:   {sc_c, sc_res} = {1'b0, a_lat} + {1'b0, b_lat};
      // Bit DW of the widened difference is set exactly when a_lat < b_lat.
      OP_SUB:   {sc_c, sc_res} = {1'b0, a_lat} - {1'b0, b_lat};
      OP_AND:   sc_res = a_lat & b_lat;
      OP_OR:    sc_res = a_lat | b_lat;
      OP_XOR:   sc_res = a_lat ^ b_lat;
      OP_PASSA: sc_res = a_lat;
      // Shifts only take this path with a zero amount: result is A unchanged.
      OP_SHL, OP_SHR, OP_SAR: sc_res = a_lat;
      default:  sc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_lat   <= '0;
      b_lat   <= '0;
      op_lat  <= '0;
      dst_lat <= '0;
      pend    <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      wben    <= 1'b0;
      err     <= 1'b0;
      wbdata  <= '0;
      wbreg   <= '0;
      flagz   <= 1'b0;
      flagc   <= 1'b0;
    end else begin
      done <= 1'b0;
      wben <= 1'b0;
      err  <= 1'b0;
      pend <= launch_single;

      if (accept) begin
        a_lat   <= opA;
        b_lat   <= opB;
        op_lat  <= opcode;
        dst_lat <= dstreg;
        shreg   <= opA;
        cnt     <= sh_in;
      end

      // pend is only ever set while the FSM stays idle, so it never overlaps
      // with the shift or multiply completion below.
      if (pend) begin
        done <= 1'b1;
        if (sc_legal) begin
          wben   <= 1'b1;
          wbdata <= sc_res;
          wbreg  <= dst_lat;
          flagz  <= (sc_res == '0);
          flagc  <= sc_c;
        end else begin
          err <= 1'b1;
        end
      end

      if (state == ST_SHIFT) begin
        shreg <= sh_step;
        cnt   <= cnt - SHW'(1);
        if (shift_last) begin
          done   <= 1'b1;
          wben   <= 1'b1;
          wbdata <= sh_step;
          wbreg  <= dst_lat;
          flagz  <= (sh_step == '0);
          flagc  <= 1'b0;
        end
      end

`ifdef ALUX_EXEC_MUL_EN
      if (mul_step && mul_last) begin
        done   <= 1'b1;
        wben   <= 1'b1;
        wbdata <= mul_res;
        wbreg  <= dst_lat;
        flagz  <= (mul_res == '0);
        flagc  <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alux_exec.sv
// tb_alux_exec: randomized scoreboard bench for alux_exec.
// The driver pushes the reference-model response for every accepted start;
// an independent monitor pops and compares on each done pulse.
module tb_alux_exec;

  localparam int DW = 64;
  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    opcode = '0;
  logic [DW-1:0] opA = '0;
  logic [DW-1:0] opB = '0;
  logic [RW-1:0] dstreg = '0;
  logic          busy, done, wben, flagz, flagc, err;
  logic [DW-1:0] wbdata;
  logic [RW-1:0] wbreg;

  alux_exec dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .opA    (opA),
    .opB    (opB),
    .dstreg (dstreg),
    .busy   (busy),
    .done   (done),
    .wbdata (wbdata),
    .wbreg  (wbreg),
    .wben   (wben),
    .flagz  (flagz),
    .flagc  (flagc),
    .err    (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint unsigned cyc;
    logic [3:0]      op;
    logic [DW-1:0]   data;
    logic [RW-1:0]   rg;
    logic            z, c, en, er;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  int              passes = 0;
  int              total  = 0;
  longint unsigned cyc    = 0;

  // Architectural state the model expects the DUT to hold between ops.
  logic [DW-1:0] m_data = '0;
  logic [RW-1:0] m_reg  = '0;
  logic          m_z = 1'b0, m_c = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference model: result, flags and latency from plain arithmetic.
  task automatic push_exp(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [RW-1:0] d, input longint unsigned k);
    exp_t          e;
    int            n;
    int            lat;
    logic [DW-1:0] r;
    logic          c;
    bit            legal;
    n = int'(b[5:0]);
    lat = 1;
    r = '0;
    c = 1'b0;
    legal = 1'b1;
    case (op)
      4'd0: begin r = a + b; c = (r < a); end
      4'd1: begin r = a - b; c = (a < b); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a;
      4'd6: r = a << n;
      4'd7: r = a >> n;
      4'd8: r = $signed(a) >>> n;
`ifdef ALUX_EXEC_MUL_EN
      4'd9: begin r = 64'(a[31:0]) * 64'(b[31:0]); lat = 32; end
`endif
      default: legal = 1'b0;
    endcase
    if (op inside {4'd6, 4'd7, 4'd8} && n != 0) lat = n;
    e.cyc = k + longint'(lat);
    e.op  = op;
    if (legal) begin
      m_data = r; m_reg = d; m_z = (r == '0); m_c = c;
    end
    e.data = m_data; e.rg = m_reg; e.z = m_z; e.c = m_c;
    e.en = legal; e.er = !legal;
    sb.push_back(e);
  endtask

  // Wait out any running op (with ignored garbage starts), then present one op.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] d);
    int guard = 0;
    while (busy && guard < 200) begin
      start  = 1'($urandom_range(0, 1));
      opcode = 4'($urandom);
      opA    = {$urandom, $urandom};
      opB    = {$urandom, $urandom};
      @(negedge clock);
      guard++;
    end
    if (busy) chk("busy_timeout", 64'(busy), 64'd0);
    start = 1'b1; opcode = op; opA = a; opB = b; dstreg = d;
    push_exp(op, a, b, d, cyc + 1);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("txn op=%0d rd=%0d data=%h z=%0d c=%0d wben=%0d err=%0d cyc=%0d",
                   mon_e.op, wbreg, wbdata, flagz, flagc, wben, err, cyc);
          chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("wbdata", wbdata, mon_e.data);
          chk("wbreg", 64'(wbreg), 64'(mon_e.rg));
          chk("flagz", 64'(flagz), 64'(mon_e.z));
          chk("flagc", 64'(flagc), 64'(mon_e.c));
          chk("wben", 64'(wben), 64'(mon_e.en));
          chk("err", 64'(err), 64'(mon_e.er));
        end
      end else begin
        chk("strobe_without_done", 64'({wben, err}), 64'd0);
      end
    end
  end

  initial begin
    int guard;
    repeat (3) @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wben", 64'(wben), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_flagz", 64'(flagz), 64'd0);
    chk("rst_flagc", 64'(flagc), 64'd0);
    chk("rst_wbdata", wbdata, 64'd0);
    chk("rst_wbreg", 64'(wbreg), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Directed cases
    issue(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
    idle(2);
    issue(4'd1, 64'd5, 64'd7, 4'd5);
    idle(2);
    issue(4'd8, 64'h8000_0000_0000_0000, 64'd4, 4'd6);
    for (int i = 0; i < 4; i++) begin
      chk("sar_busy", 64'(busy), 64'd1);
      start = 1'b1; opcode = 4'd0; opA = 64'd99; opB = 64'd1;
      @(negedge clock);
    end
    chk("sar_busy_end", 64'(busy), 64'd0);
    idle(2);
    issue(4'd9, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 4'd7);
    idle(2);
    issue(4'd4, 64'h0F0F_0000_1234_5678, 64'hFFFF_0000_0000_00FF, 4'd8);
    issue(4'd2, 64'hDEAD_BEEF_CAFE_F00D, 64'h00FF_FF00_00FF_FF00, 4'd9);
    issue(4'd12, 64'd1, 64'd2, 4'd10);
    idle(2);

    // Reset in the middle of a long operation
`ifdef ALUX_EXEC_MUL_EN
    issue(4'd9, 64'h1234_5678, 64'h9ABC_DEF0, 4'd11);
`else
    issue(4'd6, 64'd1, 64'd50, 4'd11);
`endif
    start = 1'b0;
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_wben", 64'(wben), 64'd0);
    chk("abort_wbdata", wbdata, 64'd0);
    sb.delete();
    m_data = '0; m_reg = '0; m_z = 1'b0; m_c = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    idle(40);
    issue(4'd0, 64'd2, 64'd3, 4'd1);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [3:0]    op;
      logic [DW-1:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) b = 64'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) a = '0;
      issue(op, a, b, 4'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    start = 1'b0;
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
